// File: rtl/eth_axis_fcs_inserter_128b.sv
// eth_axis_fcs_inserter_128b
// Transmit-side Ethernet FCS inserter on a 128-bit AXI4-Stream. Frames
// (destination MAC through payload) enter on s_axis. Optionally they are
// zero-padded to MIN_FRAME_LENGTH-4 bytes. The IEEE 802.3 CRC-32 is then
// appended little-endian. The output is a single register stage.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   s_axis_tdata     input data, byte n at [8n+7:8n], byte 0 sent first
//   s_axis_tkeep     byte enables (FFFF except on the last beat)
//   s_axis_tvalid    input valid
//   s_axis_tready    input ready
//   s_axis_tlast     last input beat of the frame
//   m_axis_tdata     output data, same byte order
//   m_axis_tkeep     output byte enables
//   m_axis_tvalid    output valid
//   m_axis_tready    output ready
//   m_axis_tlast     last output beat (carries the final FCS byte)
module eth_axis_fcs_inserter_128b #(
   parameter int ENABLE_PADDING   = 1,
   parameter int MIN_FRAME_LENGTH = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] s_axis_tdata,
   input  logic [15:0]  s_axis_tkeep,
   input  logic         s_axis_tvalid,
   output logic         s_axis_tready,
   input  logic         s_axis_tlast,
   output logic [127:0] m_axis_tdata,
   output logic [15:0]  m_axis_tkeep,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic         m_axis_tlast
);

   typedef enum logic [1:0] {PAYLOAD, PAD, FCS_EXTRA} state_t;

   localparam logic [16:0] PAD_LIMIT   = 17'(MIN_FRAME_LENGTH - 4);
   localparam logic [15:0] LAST_WINDOW = 16'(MIN_FRAME_LENGTH - 16);
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;

   // Reflected CRC-32 over the bytes whose mask bit is set, in byte order.
   function automatic logic [31:0] crc_update(input logic [31:0] crc_in,
                                              input logic [127:0] data,
                                              input logic [15:0] mask);
      logic [31:0] crc;
      crc = crc_in;
      for (int i = 0; i < 16; i++) begin
         if (mask[i]) begin
            crc = crc ^ {24'h0, data[8*i +: 8]};
            for (int b = 0; b < 8; b++)
               crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
         end
      end
      return crc;
   endfunction

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++)
         c = c + 5'(v[i]);
      return c;
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {12'h0, b};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   state_t        state, state_next;
   logic [31:0]   crc_state, crc_state_next;
   logic [15:0]   byte_count, byte_count_next;
   logic [31:0]   fcs_hold, fcs_hold_next;
   logic [15:0]   extra_keep, extra_keep_next;

   logic          out_en, in_fire, load;
   logic [4:0]    keep_count;
   logic [127:0]  data_masked;
   logic [16:0]   frame_len;
   logic          need_pad, in_window;
   logic [127:0]  crc_data;
   logic [15:0]   crc_mask;
   logic [31:0]   crc_calc, fcs;
   logic [127:0]  fcs_placed;
   logic [127:0]  data_next;
   logic [15:0]   keep_next;
   logic          last_next;

   assign out_en        = m_axis_tready || !m_axis_tvalid;
   assign s_axis_tready = !rst && (state == PAYLOAD) && out_en;
   assign in_fire       = s_axis_tvalid && s_axis_tready;
   assign keep_count    = popcount16(s_axis_tkeep);
   assign frame_len     = {1'b0, byte_count} + {12'h0, keep_count};
   assign need_pad      = (ENABLE_PADDING != 0) && (frame_len < PAD_LIMIT);

   // Counts are multiples of 16 until the last beat, so reaching this window
   // means the current beat is the one that must carry the FCS in bytes 12..15.
   assign in_window     = byte_count >= LAST_WINDOW;

   // Disabled byte lanes are forced to zero so padded lanes are real zeros.
   always_comb begin
      data_masked = '0;
      for (int i = 0; i < 16; i++)
         if (s_axis_tkeep[i]) data_masked[8*i +: 8] = s_axis_tdata[8*i +: 8];
   end

   // Choose which bytes feed the single CRC engine this cycle: the input
   // lanes, the input beat zero-extended for padding, or pure zero padding.
   always_comb begin
      crc_data = data_masked;
      crc_mask = s_axis_tkeep;
      if (state == PAD) begin
         crc_data = '0;
         crc_mask = in_window ? 16'h0FFF : 16'hFFFF;
      end else if (s_axis_tlast && need_pad) begin
         crc_mask = in_window ? 16'h0FFF : 16'hFFFF;
      end
   end

   assign crc_calc   = crc_update(crc_state, crc_data, crc_mask);
   assign fcs        = ~crc_calc;
   assign fcs_placed = {96'h0, fcs} << {keep_count, 3'b000};

   // Next-state and next-output-beat logic.
   always_comb begin
      state_next      = state;
      crc_state_next  = crc_state;
      byte_count_next = byte_count;
      fcs_hold_next   = fcs_hold;
      extra_keep_next = extra_keep;
      load            = 1'b0;
      data_next       = '0;
      keep_next       = '0;
      last_next       = 1'b0;
      case (state)
         PAYLOAD: begin
            if (in_fire) begin
               load           = 1'b1;
               data_next      = data_masked;
               keep_next      = 16'hFFFF;
               crc_state_next = crc_calc;
               if (!s_axis_tlast) begin
                  byte_count_next = sat_add(byte_count, keep_count);
               end else if (need_pad && !in_window) begin
                  byte_count_next = sat_add(byte_count, 5'd16);
                  state_next      = PAD;
               end else if (need_pad) begin
                  data_next = data_masked | {fcs, 96'h0};
                  last_next = 1'b1;
               end else if (keep_count <= 5'd12) begin
                  data_next = data_masked | fcs_placed;
                  keep_next = ~(16'hFFFF << (keep_count + 5'd4));
                  last_next = 1'b1;
               end else begin
                  // FCS straddles the beat boundary; keep its tail for one more beat.
                  data_next       = data_masked | fcs_placed;
                  fcs_hold_next   = fcs >> {5'd16 - keep_count, 3'b000};
                  extra_keep_next = ~(16'hFFFF << (keep_count - 5'd12));
                  state_next      = FCS_EXTRA;
               end
            end
         end
         PAD: begin
            if (out_en) begin
               load      = 1'b1;
               keep_next = 16'hFFFF;
               if (in_window) begin
                  data_next  = {fcs, 96'h0};
                  last_next  = 1'b1;
                  state_next = PAYLOAD;
               end else begin
                  crc_state_next  = crc_calc;
                  byte_count_next = sat_add(byte_count, 5'd16);
               end
            end
         end
         FCS_EXTRA: begin
            if (out_en) begin
               load       = 1'b1;
               data_next  = {96'h0, fcs_hold};
               keep_next  = extra_keep;
               last_next  = 1'b1;
               state_next = PAYLOAD;
            end
         end
         default: state_next = PAYLOAD;
      endcase
      if (load && last_next) begin
         crc_state_next  = CRC_INIT;
         byte_count_next = '0;
      end
   end

   // State and output register; the output beat only advances when the
   // downstream has taken the current one (or there is none).
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= PAYLOAD;
         crc_state     <= CRC_INIT;
         byte_count    <= '0;
         fcs_hold      <= '0;
         extra_keep    <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tkeep  <= '0;
         m_axis_tdata  <= '0;
      end else begin
         state      <= state_next;
         crc_state  <= crc_state_next;
         byte_count <= byte_count_next;
         fcs_hold   <= fcs_hold_next;
         extra_keep <= extra_keep_next;
         if (out_en) begin
            m_axis_tvalid <= load;
            if (load) begin
               m_axis_tdata <= data_next;
               m_axis_tkeep <= keep_next;
               m_axis_tlast <= last_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_eth_axis_fcs_inserter_128b.sv
// tb_eth_axis_fcs_inserter_128b
// Self-checking bench for eth_axis_fcs_inserter_128b. Two instances are
// built, one with padding and one without; "sel" routes the shared stimulus
// to one of them. Expected frames come from a table-driven CRC-32 model that
// pads and appends the FCS to a byte queue.
module tb_eth_axis_fcs_inserter_128b;

   typedef logic [7:0] u8;
   localparam int MIN_LEN = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [127:0]  s_data;
   logic [15:0]   s_keep;
   logic          s_valid, s_last;
   logic          m_ready = 1'b1;
   logic          sel;
   logic          readyRandom = 1'b0;

   logic          pad_s_ready, nop_s_ready;
   logic [127:0]  pad_m_data, nop_m_data;
   logic [15:0]   pad_m_keep, nop_m_keep;
   logic          pad_m_valid, nop_m_valid, pad_m_last, nop_m_last;

   logic          s_ready, m_valid, m_last;
   logic [127:0]  m_data;
   logic [15:0]   m_keep;

   assign s_ready = sel ? pad_s_ready : nop_s_ready;
   assign m_valid = sel ? pad_m_valid : nop_m_valid;
   assign m_last  = sel ? pad_m_last  : nop_m_last;
   assign m_data  = sel ? pad_m_data  : nop_m_data;
   assign m_keep  = sel ? pad_m_keep  : nop_m_keep;

   eth_axis_fcs_inserter_128b #(.ENABLE_PADDING(1), .MIN_FRAME_LENGTH(MIN_LEN)) dut_pad (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid && sel),
      .s_axis_tready(pad_s_ready), .s_axis_tlast(s_last),
      .m_axis_tdata(pad_m_data), .m_axis_tkeep(pad_m_keep), .m_axis_tvalid(pad_m_valid),
      .m_axis_tready(m_ready), .m_axis_tlast(pad_m_last)
   );

   eth_axis_fcs_inserter_128b #(.ENABLE_PADDING(0), .MIN_FRAME_LENGTH(MIN_LEN)) dut_nop (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid && !sel),
      .s_axis_tready(nop_s_ready), .s_axis_tlast(s_last),
      .m_axis_tdata(nop_m_data), .m_axis_tkeep(nop_m_keep), .m_axis_tvalid(nop_m_valid),
      .m_axis_tready(m_ready), .m_axis_tlast(nop_m_last)
   );

   int checks = 0;
   int errors = 0;
   int cycle  = 0;

   always @(posedge clk) cycle <= cycle + 1;

   // Output back-pressure changes just after each rising edge.
   always @(posedge clk) begin
      #1;
      m_ready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor: collects accepted beats and reassembled frames, and
   // tracks hold-stability and tkeep-shape violations.
   u8             curBytes[$];
   u8             rxBytes[$];
   int            rxLens[$];
   logic [127:0]  rxBeatData[$];
   logic [15:0]   rxBeatKeep[$];
   logic          rxBeatLast[$];
   int            rxBeatCycle[$];
   int            holdErrors = 0;
   int            keepErrors = 0;
   logic          stalled = 1'b0;
   logic [145:0]  stalledBeat;

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         curBytes.delete();
         stalled = 1'b0;
      end else begin
         if (stalled && ({m_valid, m_last, m_keep, m_data} !== stalledBeat)) holdErrors++;
         stalled     = (m_valid === 1'b1) && (m_ready === 1'b0);
         stalledBeat = {m_valid, m_last, m_keep, m_data};
         if (m_valid === 1'b1 && m_ready === 1'b1) begin
            rxBeatData.push_back(m_data);
            rxBeatKeep.push_back(m_keep);
            rxBeatLast.push_back(m_last);
            rxBeatCycle.push_back(cycle);
            if (!m_last && m_keep !== 16'hFFFF) keepErrors++;
            if (m_last && (m_keep == 16'h0 || (m_keep & (m_keep + 16'h1)) != 16'h0)) keepErrors++;
            for (int i = 0; i < 16; i++)
               if (m_keep[i]) curBytes.push_back(m_data[8*i +: 8]);
            if (m_last) begin
               rxLens.push_back(curBytes.size());
               foreach (curBytes[i]) rxBytes.push_back(curBytes[i]);
               curBytes.delete();
            end
         end
      end
   end

   initial begin
      #3ms;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model
   logic [31:0] crcTable [256];

   function automatic void buildTable();
      logic [31:0] c;
      for (int i = 0; i < 256; i++) begin
         c = 32'(i);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         crcTable[i] = c;
      end
   endfunction

   function automatic logic [31:0] crcBytes(input logic [31:0] init, input u8 data[$]);
      logic [31:0] c;
      c = init;
      foreach (data[i]) c = crcTable[c[7:0] ^ data[i]] ^ (c >> 8);
      return c;
   endfunction

   function automatic void modelFrame(input u8 frame[$], input bit pad, output u8 out[$]);
      logic [31:0] f;
      out = frame;
      if (pad) while (out.size() < MIN_LEN - 4) out.push_back(8'h00);
      f = ~crcBytes(32'hFFFFFFFF, out);
      for (int i = 0; i < 4; i++) out.push_back(f[8*i +: 8]);
   endfunction

   // Checking and stimulus tasks
   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkInt(input string tag, input int observed, input int expected);
      checkOutput(tag, 128'(observed), 128'(expected));
   endtask

   task automatic clearRx();
      rxBytes.delete(); rxLens.delete();
      rxBeatData.delete(); rxBeatKeep.delete(); rxBeatLast.delete(); rxBeatCycle.delete();
   endtask

   task automatic applyStimulus(input u8 frame[$]);
      int nBeats;
      int waitCount;
      nBeats = (frame.size() + 15) / 16;
      for (int b = 0; b < nBeats; b++) begin
         s_data = '0;
         s_keep = '0;
         for (int i = 0; i < 16; i++)
            if (b * 16 + i < frame.size()) begin
               s_data[8*i +: 8] = frame[b * 16 + i];
               s_keep[i] = 1'b1;
            end
         s_last  = (b == nBeats - 1);
         s_valid = 1'b1;
         waitCount = 0;
         @(negedge clk);
         while (!s_ready && waitCount < 2000) begin
            @(negedge clk);
            waitCount++;
         end
         if (!s_ready) begin
            checkOutput("s_ready_timeout", 128'(s_ready), 128'(1'b1));
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic waitFrames(input int n, input string tag);
      int budget;
      budget = 0;
      while (rxLens.size() < n && budget < 5000) begin
         @(posedge clk);
         #1;
         budget++;
      end
      checkInt(tag, rxLens.size(), n);
   endtask

   task automatic compareBytes(input string tag, input u8 expq[$]);
      int bad;
      bad = 0;
      foreach (expq[i]) if (i >= rxBytes.size() || rxBytes[i] !== expq[i]) bad++;
      checkInt({tag, "_len"}, rxBytes.size(), expq.size());
      checkInt({tag, "_bad_bytes"}, bad, 0);
   endtask

   task automatic makeFrame(input int len, output u8 frame[$]);
      frame.delete();
      for (int i = 0; i < len; i++) frame.push_back(u8'($urandom));
   endtask

   u8           frame[$];
   u8           expq[$];
   u8           rxFrame[$];
   u8           expBytes[$];
   int          expLens[$];
   logic [31:0] fcs;
   int          len, rxOff, expOff, bad, gotLen;

   initial begin
      buildTable();
      rst = 1'b1; sel = 1'b0;
      s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_keep = '0;
      repeat (3) @(posedge clk);
      #1;

      // Reset state of both instances
      checkOutput("rst_nop_m_valid", 128'(nop_m_valid), 128'(1'b0));
      checkOutput("rst_nop_m_last",  128'(nop_m_last),  128'(1'b0));
      checkOutput("rst_nop_m_keep",  128'(nop_m_keep),  128'(16'h0));
      checkOutput("rst_nop_m_data",  nop_m_data,        128'h0);
      checkOutput("rst_nop_s_ready", 128'(nop_s_ready), 128'(1'b0));
      checkOutput("rst_pad_m_valid", 128'(pad_m_valid), 128'(1'b0));
      checkOutput("rst_pad_s_ready", 128'(pad_s_ready), 128'(1'b0));
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("idle_nop_s_ready", 128'(nop_s_ready), 128'(1'b1));

      // "123456789" without padding: FCS CB F4 39 26 in bytes 9..12
      sel = 1'b0; clearRx();
      frame.delete();
      for (int i = 0; i < 9; i++) frame.push_back(u8'(8'h31 + i));
      applyStimulus(frame);
      waitFrames(1, "t1_frames");
      checkInt("t1_beats", rxBeatData.size(), 1);
      checkOutput("t1_keep", 128'(rxBeatKeep[0]), 128'(16'h1FFF));
      checkOutput("t1_last", 128'(rxBeatLast[0]), 128'(1'b1));
      checkOutput("t1_payload", 128'(rxBeatData[0][71:0]), 128'(72'h393837363534333231));
      checkOutput("t1_fcs", 128'(rxBeatData[0][103:72]), 128'(32'hCBF43926));

      // Same frame with padding: four contiguous full beats, 64 bytes
      sel = 1'b1; clearRx();
      applyStimulus(frame);
      waitFrames(1, "t2_frames");
      checkInt("t2_beats", rxBeatData.size(), 4);
      for (int b = 0; b < 4; b++) begin
         checkOutput($sformatf("t2_keep%0d", b), 128'(rxBeatKeep[b]), 128'(16'hFFFF));
         checkOutput($sformatf("t2_last%0d", b), 128'(rxBeatLast[b]), 128'(b == 3));
      end
      checkInt("t2_contiguous", rxBeatCycle[3] - rxBeatCycle[0], 3);
      modelFrame(frame, 1'b1, expq);
      compareBytes("t2", expq);

      // 13-byte frame without padding: FCS split across two beats
      sel = 1'b0; clearRx();
      makeFrame(13, frame);
      fcs = ~crcBytes(32'hFFFFFFFF, frame);
      applyStimulus(frame);
      waitFrames(1, "t3_frames");
      checkInt("t3_beats", rxBeatData.size(), 2);
      checkOutput("t3_keep0", 128'(rxBeatKeep[0]), 128'(16'hFFFF));
      checkOutput("t3_last0", 128'(rxBeatLast[0]), 128'(1'b0));
      checkOutput("t3_fcs_lo", 128'(rxBeatData[0][127:104]), 128'(fcs[23:0]));
      checkOutput("t3_keep1", 128'(rxBeatKeep[1]), 128'(16'h0001));
      checkOutput("t3_last1", 128'(rxBeatLast[1]), 128'(1'b1));
      checkOutput("t3_fcs_hi", 128'(rxBeatData[1][7:0]), 128'(fcs[31:24]));

      // 64-byte frame with padding on: no padding, one FCS_EXTRA beat
      sel = 1'b1; clearRx();
      makeFrame(64, frame);
      applyStimulus(frame);
      checkOutput("t4_s_ready_extra", 128'(s_ready), 128'(1'b0));
      @(posedge clk);
      #1;
      checkOutput("t4_s_ready_after", 128'(s_ready), 128'(1'b1));
      waitFrames(1, "t4_frames");
      checkInt("t4_beats", rxBeatData.size(), 5);
      checkOutput("t4_last_keep", 128'(rxBeatKeep[4]), 128'(16'h000F));
      modelFrame(frame, 1'b1, expq);
      compareBytes("t4", expq);

      // Reset during beat 3 of a 10-beat frame, then a clean 9-byte frame
      sel = 1'b0; clearRx();
      for (int b = 0; b < 3; b++) begin
         s_data  = {$urandom, $urandom, $urandom, $urandom};
         s_keep  = 16'hFFFF;
         s_last  = 1'b0;
         s_valid = 1'b1;
         if (b == 2) rst = 1'b1;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("t6_m_valid_after_rst", 128'(nop_m_valid), 128'(1'b0));
      clearRx();
      frame.delete();
      for (int i = 0; i < 9; i++) frame.push_back(u8'(8'h31 + i));
      applyStimulus(frame);
      waitFrames(1, "t6_frames");
      repeat (10) @(posedge clk);
      #1;
      checkInt("t6_frame_count", rxLens.size(), 1);
      checkInt("t6_beats", rxBeatData.size(), 1);
      checkOutput("t6_fcs", 128'(rxBeatData[0][103:72]), 128'(32'hCBF43926));
      modelFrame(frame, 1'b0, expq);
      compareBytes("t6", expq);

      // Random frames under random back-pressure, both instances
      readyRandom = 1'b1;
      for (int p = 0; p < 2; p++) begin
         sel = p[0];
         clearRx();
         expBytes.delete();
         expLens.delete();
         for (int f = 0; f < 500; f++) begin
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 1514)) : int'($urandom_range(1, 128));
            makeFrame(len, frame);
            modelFrame(frame, p[0], expq);
            expLens.push_back(expq.size());
            foreach (expq[i]) expBytes.push_back(expq[i]);
            applyStimulus(frame);
            if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
         end
         waitFrames(500, $sformatf("rand%0d_frames", p));
         rxOff = 0;
         expOff = 0;
         for (int f = 0; f < 500; f++) begin
            gotLen = (f < rxLens.size()) ? rxLens[f] : 0;
            checkInt($sformatf("rand%0d_f%0d_len", p, f), gotLen, expLens[f]);
            bad = 0;
            rxFrame.delete();
            for (int i = 0; i < gotLen; i++) rxFrame.push_back(rxBytes[rxOff + i]);
            for (int i = 0; i < expLens[f]; i++)
               if (i >= gotLen || rxFrame[i] !== expBytes[expOff + i]) bad++;
            checkInt($sformatf("rand%0d_f%0d_bytes", p, f), bad, 0);
            checkOutput($sformatf("rand%0d_f%0d_residue", p, f),
                        128'(crcBytes(32'hFFFFFFFF, rxFrame)), 128'(32'hDEBB20E3));
            rxOff  += gotLen;
            expOff += expLens[f];
         end
      end
      readyRandom = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      checkInt("hold_violations", holdErrors, 0);
      checkInt("keep_violations", keepErrors, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/eth_axis_fcs_inserter_128b.md
Name: eth_axis_fcs_inserter_128b

Overview:
Transmit-side counterpart of the 128-bit FCS checker. Takes Ethernet frames (destination MAC through payload, no FCS) on a 128-bit AXI4-Stream, optionally zero-pads them to the 60-byte minimum, computes CRC-32 (IEEE 802.3), and appends the 4-byte FCS. It sits between frame generation and the MAC/PHY transmit path.

Parameters:
ENABLE_PADDING, 1, when 1, frames shorter than MIN_FRAME_LENGTH-4 bytes are zero-padded before the FCS is appended.
MIN_FRAME_LENGTH, 64, minimum output frame length in bytes, FCS included. Must be a multiple of 16 and at least 32.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
s_axis_tdata  in  128  input data; byte n at [8n+7:8n]; byte 0 is transmitted first
s_axis_tkeep  in  16  byte enables; must be 16'hFFFF on non-last beats; contiguous from bit 0 on the last beat, at least 1 bit set
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat of frame
m_axis_tdata  out  128  output data, same byte order
m_axis_tkeep  out  16  output byte enables
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last beat of output frame (carries the final FCS byte)

Behaviour:
- Reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0, CRC state=32'hFFFFFFFF, byte counter=0, FSM=PAYLOAD. s_axis_tready is 0 while rst is high. Reset in mid-frame discards the partial frame, and the next beat starts a new frame.
- Output is a single register stage. Latency is 1 cycle from input handshake to m_axis_tvalid. The output register loads when m_axis_tready || !m_axis_tvalid.
- s_axis_tready = (state==PAYLOAD) && (m_axis_tready || !m_axis_tvalid). It is 0 in the PAD and FCS_EXTRA states.
- CRC: reflected poly 32'hEDB88320, init all ones, FCS = ~state. The FCS is appended little-endian: FCS[7:0] is the first byte. Full beats use a 16-byte combinational update. The last beat updates over the popcount(tkeep) low bytes only, using byte-granular logic selected by tkeep. Padding bytes are 8'h00 and are included in the CRC.
- Byte counter: 16-bit, counts payload plus pad bytes and saturates at 16'hFFFF. It is used only for the padding decision.
- FSM:
  - PAYLOAD: each non-last beat passes through with tkeep=FFFF and tlast=0. On the last beat, let L be the total frame byte count including this beat, and N = popcount(tkeep).
    - If padding is needed (ENABLE_PADDING and L < MIN_FRAME_LENGTH-4): pad the current beat to 16 bytes with zeros, emit it with tlast=0, and go to PAD.
    - Else if N <= 12: the FCS goes into bytes N..N+3, tkeep has N+4 low bits set, tlast=1, and the FSM stays in PAYLOAD.
    - Else (N > 12): bytes N..15 carry the first 16-N FCS bytes, tkeep=FFFF, tlast=0. Go to FCS_EXTRA with the remaining N-12 bytes pending.
  - PAD: emit all-zero beats, tkeep=FFFF. The beat that brings the count to MIN_FRAME_LENGTH-4 instead carries zeros in bytes 0..11 and the FCS in bytes 12..15, with tlast=1. Then return to PAYLOAD.
  - FCS_EXTRA: emit the remaining FCS bytes in bytes 0..N-13, tkeep=(1<<(N-12))-1, tlast=1. Return to PAYLOAD.
- CRC state and byte counter return to their initial values when the output beat carrying m_axis_tlast is loaded into the output register.
- When m_axis_tready is low, the output holds steady: tdata, tkeep and tlast stay stable while tvalid=1, and no beat is dropped or duplicated.
- A back-to-back frame with no gap is accepted on the cycle after a single-beat tlast output, with no bubble in PAYLOAD.
- Malformed tkeep (non-contiguous, or non-FFFF on a non-last beat) is outside the contract; behaviour is unspecified but the block must not hang.

Test Plan:
- ENABLE_PADDING=0; one beat of bytes "123456789" (0x31..0x39), tkeep=01FF, tlast -> one output beat: bytes 9..12 = 26 39 F4 CB, tkeep=1FFF, tlast=1.
- ENABLE_PADDING=1; same 9-byte frame -> 4 beats, 64 bytes total: bytes 9..59 are zero, bytes 60..63 hold the CRC of the 60-byte buffer, last tkeep=FFFF, and the beats are contiguous under constant tready.
- ENABLE_PADDING=0; 13-byte frame (tkeep=1FFF) -> beat 1: tkeep=FFFF, tlast=0, bytes 13..15 = FCS[23:0]; beat 2: tkeep=0001, byte 0 = FCS[31:24], tlast=1. Checked against a software CRC.
- 64-byte frame (four full beats, fourth tkeep=FFFF) with padding on -> no padding; output 4 full beats plus an FCS_EXTRA beat with tkeep=000F. s_axis_tready=0 during that extra cycle.
- Random m_axis_tready (about 50% duty) over 1000 random frames of 1-1514 bytes -> every output frame passes the receive-side FCS checker, and the byte streams match a reference model.
- Assert rst during beat 3 of a 10-beat frame, then send a clean 9-byte frame -> only the clean frame appears after reset, with the correct FCS 26 39 F4 CB (padding off).
